// File: rtl/acsi_initiator.sv
// acsi_initiator: host-side ACSI command sequencer.
//
// Sends a 6..16 byte command descriptor over the ACSI register bus. It waits for
// the target IRQ after each byte, then for the completion IRQ. It then reads the
// status byte and reports a result code.
//
// Ports:
//   i_clk, i_reset      clock; synchronous active-high reset
//   i_clk_en            bus tick enable; all bus timing advances on ticks only
//   i_cmd_wr/waddr/wdata  descriptor buffer write port (ignored while busy)
//   i_cmd_target/len    target ID and command length, latched at start
//   i_cmd_start         start pulse (ignored while busy or during done)
//   o_busy, o_done      command in progress / one-cycle completion pulse
//   o_result            0 ok, 1 check, 2 timeout, 3 rejected
//   o_status            last status byte read from the target
//   o_acsi_*            register bus strobes and write data
//   i_acsi_din          status read data
//   i_acsi_irq          target IRQ, level, active-high
//
// Build option: define ACSI_INITIATOR_ICD_EN to send opcodes >= 0x20 with the ICD
// escape byte. Without it, such commands are rejected with no bus activity.

module acsi_initiator #(
    parameter int unsigned SEL_TICKS    = 2,
    parameter int unsigned GAP_TICKS    = 1,
    parameter int unsigned BYTE_TIMEOUT = 1024,
    parameter int unsigned CMD_TW       = 24
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clk_en,
    input  logic       i_cmd_wr,
    input  logic [3:0] i_cmd_waddr,
    input  logic [7:0] i_cmd_wdata,
    input  logic [2:0] i_cmd_target,
    input  logic [4:0] i_cmd_len,
    input  logic       i_cmd_start,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_result,
    output logic [7:0] o_status,
    output logic       o_acsi_sel,
    output logic       o_acsi_rw,
    output logic       o_acsi_a1,
    output logic [7:0] o_acsi_dout,
    input  logic [7:0] i_acsi_din,
    input  logic       i_acsi_irq
);

    localparam int unsigned ToW  = $clog2(BYTE_TIMEOUT + 1);
    localparam int unsigned CntW = (CMD_TW > ToW) ? CMD_TW : ToW;

    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] SelLast  = CntW'(SEL_TICKS - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_TICKS - 1);
    localparam logic [CntW-1:0] AckLast  = CntW'(BYTE_TIMEOUT - 1);
    localparam logic [CntW-1:0] DoneLim  = CntW'({CMD_TW{1'b1}});
    localparam logic [CntW-1:0] DoneLast = DoneLim - CntOne;

    typedef enum logic [2:0] {
        StIdle, StSel, StGap, StWaitAck, StWaitDone, StRdSel, StRdGap, StFinish
    } state_e;

    state_e          r_state, w_state_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]      r_buf [16];
    logic            r_first;   // current byte is the first (a1=0) byte
    logic [3:0]      r_ptr;     // buffer index of the current non-first byte
    logic [4:0]      r_rem;     // bytes still to send after the current one
    logic [2:0]      r_target;
    logic            r_icd;
    logic [1:0]      r_fin, w_fin_nxt;
    logic [1:0]      r_result;
    logic [7:0]      r_status;
    logic            r_done;

    logic       w_start, w_len_bad, w_esc, w_reject, w_advance, w_capture;
    logic       w_wr_phase, w_rd_phase;
    logic [7:0] w_op, w_byte;

    // A buffer write in the start cycle must already count for the opcode check.
    assign w_op      = (i_cmd_wr && i_cmd_waddr == 4'd0) ? i_cmd_wdata : r_buf[0];
    assign w_start   = i_cmd_start && (r_state == StIdle) && !r_done;
    assign w_len_bad = (i_cmd_len < 5'd6) || (i_cmd_len > 5'd16);
    assign w_esc     = (w_op >= 8'h20);

`ifdef ACSI_INITIATOR_ICD_EN
    assign w_reject = w_len_bad;
`else
    assign w_reject = w_len_bad || w_esc;
`endif

    always_ff @(posedge i_clk) begin
        if (i_cmd_wr && r_state == StIdle) begin
            r_buf[i_cmd_waddr] <= i_cmd_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_first  <= 1'b1;
            r_ptr    <= 4'd0;
            r_rem    <= 5'd0;
            r_target <= 3'd0;
            r_icd    <= 1'b0;
            r_fin    <= 2'd0;
            r_result <= 2'd0;
            r_status <= 8'h00;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fin   <= w_fin_nxt;
            r_done  <= (r_state == StFinish);
            if (r_state == StFinish) begin
                r_result <= r_fin;
            end
            if (w_start) begin
                r_target <= i_cmd_target;
                r_icd    <= w_esc;
                r_first  <= 1'b1;
                // Escape mode sends an extra leading byte, then buf[0..len-1].
                r_ptr    <= w_esc ? 4'd0 : 4'd1;
                r_rem    <= w_esc ? i_cmd_len : i_cmd_len - 5'd1;
            end
            if (w_advance) begin
                r_first <= 1'b0;
                r_rem   <= r_rem - 5'd1;
                if (!r_first) begin
                    r_ptr <= r_ptr + 4'd1;
                end
            end
            if (w_capture) begin
                r_status <= i_acsi_din;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fin_nxt   = r_fin;
        w_advance   = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    if (w_reject) begin
                        w_fin_nxt   = 2'd3;
                        w_state_nxt = StFinish;
                    end else begin
                        w_state_nxt = StSel;
                    end
                end
            end
            StSel: begin
                if (i_clk_en) begin
                    if (r_cnt == SelLast) w_state_nxt = StGap;
                    else                  w_cnt_nxt   = r_cnt + CntOne;
                end
            end
            StGap: begin
                if (i_clk_en) begin
                    if (r_cnt == GapLast) w_state_nxt = (r_rem == 5'd0) ? StWaitDone : StWaitAck;
                    else                  w_cnt_nxt   = r_cnt + CntOne;
                end
            end
            StWaitAck: begin
                if (i_clk_en) begin
                    if (i_acsi_irq) begin
                        w_advance   = 1'b1;
                        w_state_nxt = StSel;
                    end else if (r_cnt == AckLast) begin
                        w_fin_nxt   = 2'd2;
                        w_state_nxt = StFinish;
                    end else begin
                        w_cnt_nxt = r_cnt + CntOne;
                    end
                end
            end
            StWaitDone: begin
                if (i_clk_en) begin
                    if (i_acsi_irq) begin
                        w_state_nxt = StRdSel;
                    end else if (r_cnt == DoneLast) begin
                        w_fin_nxt   = 2'd2;
                        w_state_nxt = StFinish;
                    end else begin
                        w_cnt_nxt = r_cnt + CntOne;
                    end
                end
            end
            StRdSel: begin
                if (i_clk_en) begin
                    if (r_cnt == SelLast) begin
                        w_capture   = 1'b1;
                        w_state_nxt = StRdGap;
                    end else begin
                        w_cnt_nxt = r_cnt + CntOne;
                    end
                end
            end
            StRdGap: begin
                if (i_clk_en) begin
                    if (r_cnt == GapLast) begin
                        w_fin_nxt   = {1'b0, r_status[1]};
                        w_state_nxt = StFinish;
                    end else begin
                        w_cnt_nxt = r_cnt + CntOne;
                    end
                end
            end
            StFinish: w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
        // Every state entry starts its tick count from zero.
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end
    end

    assign w_wr_phase = (r_state == StSel) || (r_state == StGap);
    assign w_rd_phase = (r_state == StRdSel) || (r_state == StRdGap);
    assign w_byte     = r_first ? {r_target, (r_icd ? 5'h1f : r_buf[0][4:0])} : r_buf[r_ptr];

    assign o_busy      = (r_state != StIdle);
    assign o_done      = r_done;
    assign o_result    = r_result;
    assign o_status    = r_status;
    assign o_acsi_sel  = (r_state == StSel) || (r_state == StRdSel);
    assign o_acsi_rw   = !w_wr_phase;
    assign o_acsi_a1   = w_rd_phase || (w_wr_phase && !r_first);
    assign o_acsi_dout = w_wr_phase ? w_byte : 8'h00;

endmodule

// File: doc/acsi_initiator.md
# acsi_initiator

Host-side ACSI command sequencer: the initiator end of the byte-wise ACSI command protocol served by the core's ACSI disk target. It takes a command descriptor of 6–16 bytes from a loader port and transmits it over a CPU-style register bus (A1/SEL/RW strobes, 8-bit data). It waits for the target's IRQ handshake after every byte and for the completion IRQ, then reads the status byte and reports a result code. It sits between a host/test controller and any target that uses the same register interface, and is usable as an on-chip bus-functional master.

## Interface
Parameters:
- SEL_TICKS, 2: clk_en ticks that acsi_sel is held high per access.
- GAP_TICKS, 1: clk_en ticks that acsi_sel is held low after each access.
- BYTE_TIMEOUT, 1024: clk_en ticks allowed for the per-byte IRQ acknowledge.
- CMD_TW, 24: width of the completion timeout counter; the limit is 2^CMD_TW−1 ticks.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- clk_en  in  1  bus tick enable; all bus timing advances only when this is high
- cmd_wr  in  1  write one descriptor byte; ignored while busy
- cmd_waddr  in  4  byte index 0..15
- cmd_wdata  in  8  byte value; byte 0 is the opcode
- cmd_target  in  3  target ID, latched at start
- cmd_len  in  5  total command length, latched at start; legal range 6..16
- cmd_start  in  1  single-cycle start pulse; ignored while busy
- busy  out  1  high from the accepted start until done
- done  out  1  one-clk pulse at the end of a command
- result  out  2  0 ok, 1 check (status bit 1 set), 2 timeout, 3 rejected
- status  out  8  last status byte read from the target
- acsi_sel  out  1  register select
- acsi_rw  out  1  1 = read, 0 = write
- acsi_a1  out  1  0 = first command byte, 1 = further bytes or status
- acsi_dout  out  8  write data
- acsi_din  in  8  read data (status byte)
- acsi_irq  in  1  target IRQ, level, active-high

## Operation
- Reset values: busy=0, done=0, result=0, status=0, acsi_sel=0, acsi_rw=1, acsi_a1=0, acsi_dout=0. Reset mid-command aborts at once; the descriptor buffer contents are kept.
- The descriptor buffer is 16×8 and written directly by cmd_wr.
- States: IDLE, SEL, GAP, WAIT_ACK, WAIT_DONE, RD_SEL, RD_GAP, FINISH.
- IDLE:
  - On cmd_start, latch target and len, and set busy.
  - If len<6 or len>16, go to FINISH with result=3.
- First byte: a1=0, dout={target, opcode[4:0]}. Opcodes ≥0x20 follow the Configuration section.
- Further bytes: a1=1, dout=buf[i], for i=1..len−1.
- Per byte:
  - SEL: sel=1, rw=0, for SEL_TICKS ticks.
  - GAP: sel=0, for GAP_TICKS ticks.
- After every byte except the last, go to WAIT_ACK. It waits for acsi_irq=1, sampled on clk_en ticks only. The target clears IRQ on the select edge, so a level seen after GAP is fresh.
- After the last byte, go to WAIT_DONE, which waits for acsi_irq with the completion timeout. The target may raise IRQ immediately on error or after its data phase.
- Status read:
  - RD_SEL: sel=1, rw=1, a1=1. acsi_din is captured into status on the final SEL tick.
  - RD_GAP follows, then FINISH.
- FINISH: result=0, or 1 if status[1]=1. Pulse done, clear busy, return to IDLE.
- Timeouts:
  - WAIT_ACK with no IRQ for BYTE_TIMEOUT ticks, or WAIT_DONE with no IRQ for 2^CMD_TW−1 ticks: sel=0, skip the status read, FINISH with result=2.
  - status keeps its previous value.
- Counters reset on every state entry.

## Timing
- cmd_start to acsi_sel rising: 1st clk_en tick after start.
- One write access occupies SEL_TICKS+GAP_TICKS ticks, plus the WAIT_ACK duration.
- IRQ already high on the first WAIT_ACK tick: advance on that same tick; zero wait.
- done asserts in the clk cycle after FINISH is entered and is a single-cycle pulse.
- busy falls in the same cycle as done.
- cmd_start coincident with done is ignored.
- cmd_wr coincident with cmd_start is accepted, since busy is still low; the write lands before latching is used.

## Configuration
- ACSI_INITIATOR_ICD_EN defined:
  - Opcodes ≥0x20 use the ICD escape. The first byte is {target, 5'h1f} with a1=0.
  - All len bytes buf[0..len−1] then follow with a1=1, so total bus writes = len+1.
- ACSI_INITIATOR_ICD_EN undefined:
  - Opcodes ≥0x20 are not transmitted. FINISH with result=3; no bus activity.

## Test plan
- Test unit ready: target 0, bytes 00 00 00 00 00 00, target model acks each byte and raises completion IRQ with status 0x00 -> 6 writes (first dout=0x00, a1=0), 1 read, result=0, done pulse.
- Check status: target 1, opcode 0x12, completion status 0x02 -> first dout=0x32, status=0x02, result=1.
- Ack timeout: model never raises IRQ after byte 2 -> exactly BYTE_TIMEOUT ticks of WAIT_ACK, then result=2, acsi_sel=0, no read access.
- Opcode 0x28, len 10, target 0:
  - With ICD_EN: 11 writes, first dout=0x1F, second dout=0x28, result=0.
  - Without ICD_EN: zero writes, result=3.
- cmd_len=5 -> result=3, done within 2 ticks, no bus activity.
- Reset asserted during SEL of byte 3 -> next cycle sel=0, busy=0, done=0. A fresh start then completes normally.
